// File: rtl/axi4l_reg_slave.sv
// axi4l_reg_slave: AXI4-Lite subordinate holding NUM_REGS read/write registers.
// Register contents are exported flat on reg_q, with a one-cycle wr_pulse per
// register on every committed write.
// Build option: define AXI4L_REGS_ID_EN to make index 0 a read-only ID register
// that always reads ID_VALUE and rejects writes with SLVERR.
module axi4l_reg_slave #(
    parameter int          NUM_REGS   = 16,
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] ID_VALUE   = 32'hA5A5_0001
) (
    input  logic                           axi4l_aclk,
    input  logic                           axi4l_arstn,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int NB    = DATA_WIDTH / 8;

    typedef enum logic [0:0] {
        WR_IDLE = 1'b0,
        WR_RESP = 1'b1
    } wr_state_t;

    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
    logic                  alive_r;
    wr_state_t             wr_state_r;
    wr_state_t             wr_state_nxt_s;
    logic                  commit_s;
    logic                  aw_held_r;
    logic                  w_held_r;
    logic [IDX_W-1:0]      aw_idx_r;
    logic [DATA_WIDTH-1:0] w_data_r;
    logic [NB-1:0]         w_strb_r;
    logic [1:0]            bresp_r;
    logic [NUM_REGS-1:0]   wr_pulse_r;
    logic                  rvalid_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic [1:0]            rresp_r;
    logic                  bvalid_s;
    logic                  awready_s;
    logic                  wready_s;
    logic                  arready_s;
    logic                  aw_hs_s;
    logic                  w_hs_s;
    logic                  ar_hs_s;
    logic                  wr_ok_s;
    logic [IDX_W-1:0]      ar_idx_s;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic [1:0]            rd_resp_s;
    logic                  unused_s;

    // True when the word index addresses an implemented register.
    function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
        return (idx < IDX_W'(NUM_REGS));
    endfunction

    // True when a write to this index may change a register.
    function automatic logic idx_writable(input logic [IDX_W-1:0] idx);
`ifdef AXI4L_REGS_ID_EN
        return idx_in_range(idx) && (idx != {IDX_W{1'b0}});
`else
        return idx_in_range(idx);
`endif
    endfunction

    // Byte offset bits are ignored by the word decode.
`ifdef AXI4L_REGS_ID_EN
    assign unused_s = ^{awaddr[1:0], araddr[1:0]};
`else
    assign unused_s = ^{awaddr[1:0], araddr[1:0], ID_VALUE};
`endif

    // Ready signals stay low in reset and rise on the first edge after release.
    assign bvalid_s  = (wr_state_r == WR_RESP);
    assign awready_s = alive_r && !aw_held_r && !bvalid_s;
    assign wready_s  = alive_r && !w_held_r && !bvalid_s;
    assign arready_s = alive_r && !rvalid_r;
    assign aw_hs_s   = awvalid && awready_s;
    assign w_hs_s    = wvalid && wready_s;
    assign ar_hs_s   = arvalid && arready_s;
    assign wr_ok_s   = idx_writable(aw_idx_r);
    assign ar_idx_s  = araddr[ADDR_WIDTH-1:2];

    assign awready  = awready_s;
    assign wready   = wready_s;
    assign arready  = arready_s;
    assign bvalid   = bvalid_s;
    assign bresp    = bresp_r;
    assign rvalid   = rvalid_r;
    assign rdata    = rdata_r;
    assign rresp    = rresp_r;
    assign wr_pulse = wr_pulse_r;

    // Marks the block as out of reset one edge after release.
    always_ff @(posedge axi4l_aclk or posedge axi4l_arstn) begin
        if (axi4l_arstn) begin
            alive_r <= 1'b0;
        end else begin
            alive_r <= 1'b1;
        end
    end

    // Write FSM state register.
    always_ff @(posedge axi4l_aclk or posedge axi4l_arstn) begin
        if (axi4l_arstn) begin
            wr_state_r <= WR_IDLE;
        end else begin
            wr_state_r <= wr_state_nxt_s;
        end
    end

    // Write FSM: commit once both halves are held, then wait for bready.
    always_comb begin
        wr_state_nxt_s = wr_state_r;
        commit_s       = 1'b0;
        case (wr_state_r)
            WR_IDLE: begin
                if (aw_held_r && w_held_r) begin
                    commit_s       = 1'b1;
                    wr_state_nxt_s = WR_RESP;
                end else begin
                    wr_state_nxt_s = WR_IDLE;
                end
            end
            WR_RESP: begin
                if (bready) begin
                    wr_state_nxt_s = WR_IDLE;
                end else begin
                    wr_state_nxt_s = WR_RESP;
                end
            end
            default: begin
                wr_state_nxt_s = WR_IDLE;
            end
        endcase
    end

    // AW and W holding registers, filled independently and cleared on commit.
    always_ff @(posedge axi4l_aclk or posedge axi4l_arstn) begin
        if (axi4l_arstn) begin
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            aw_idx_r  <= {IDX_W{1'b0}};
            w_data_r  <= {DATA_WIDTH{1'b0}};
            w_strb_r  <= {NB{1'b0}};
        end else if (commit_s) begin
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
        end else begin
            if (aw_hs_s) begin
                aw_held_r <= 1'b1;
                aw_idx_r  <= awaddr[ADDR_WIDTH-1:2];
            end
            if (w_hs_s) begin
                w_held_r <= 1'b1;
                w_data_r <= wdata;
                w_strb_r <= wstrb;
            end
        end
    end

    // Write response code, fixed at commit and held until bready.
    always_ff @(posedge axi4l_aclk or posedge axi4l_arstn) begin
        if (axi4l_arstn) begin
            bresp_r <= 2'b00;
        end else if (commit_s) begin
            bresp_r <= wr_ok_s ? 2'b00 : 2'b10;
        end else begin
            bresp_r <= bresp_r;
        end
    end

    // Register bank update with byte enables and per-register write strobe.
    always_ff @(posedge axi4l_aclk or posedge axi4l_arstn) begin
        if (axi4l_arstn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
            wr_pulse_r <= {NUM_REGS{1'b0}};
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                wr_pulse_r[i] <= commit_s && wr_ok_s && (aw_idx_r == IDX_W'(i));
                if (commit_s && wr_ok_s && (aw_idx_r == IDX_W'(i))) begin
                    for (int b = 0; b < NB; b++) begin
                        if (w_strb_r[b]) begin
                            regs_r[i][8*b +: 8] <= w_data_r[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read-data selection for the address on AR; sees pre-write register values.
    always_comb begin
        rd_data_s = {DATA_WIDTH{1'b0}};
        rd_resp_s = 2'b10;
        if (idx_in_range(ar_idx_s)) begin
            rd_resp_s = 2'b00;
            for (int i = 0; i < NUM_REGS; i++) begin
                rd_data_s = (ar_idx_s == IDX_W'(i)) ? regs_r[i] : rd_data_s;
            end
`ifdef AXI4L_REGS_ID_EN
            rd_data_s = (ar_idx_s == {IDX_W{1'b0}}) ? ID_VALUE : rd_data_s;
`endif
        end else begin
            rd_data_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Read channel: capture on AR handshake, hold until rready.
    always_ff @(posedge axi4l_aclk or posedge axi4l_arstn) begin
        if (axi4l_arstn) begin
            rvalid_r <= 1'b0;
            rdata_r  <= {DATA_WIDTH{1'b0}};
            rresp_r  <= 2'b00;
        end else if (ar_hs_s) begin
            rvalid_r <= 1'b1;
            rdata_r  <= rd_data_s;
            rresp_r  <= rd_resp_s;
        end else if (rvalid_r && rready) begin
            rvalid_r <= 1'b0;
        end else begin
            rvalid_r <= rvalid_r;
        end
    end

    // Flat export of the register bank.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_r[i];
        end
`ifdef AXI4L_REGS_ID_EN
        reg_q[DATA_WIDTH-1:0] = ID_VALUE;
`endif
    end

endmodule

// File: doc/axi4l_reg_slave.md
Name: axi4l_reg_slave

Overview:
- AXI4-Lite responder holding a bank of NUM_REGS 32-bit read/write control registers.
- It is the subordinate end of the axi4l_if link driven by the m_axi4l_bfm master.
- It replaces ad-hoc bench slaves with a compliant, synthesizable register file.
- Register contents are exported flat to fabric logic, with a per-register write pulse.

Parameters:
- NUM_REGS, 16, number of 32-bit registers; legal range 1..256.
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width; only 32 is supported.
- ID_VALUE, 32'hA5A5_0001, constant read at index 0 when AXI4L_REGS_ID_EN is defined.

Ports:
- axi4l_aclk  in  1  clock
- axi4l_arstn  in  1  reset
- awaddr  in  ADDR_WIDTH  write address
- awvalid  in  1 / awready  out  1  write-address handshake
- wdata  in  32 / wstrb  in  4  write data, byte enables
- wvalid  in  1 / wready  out  1  write-data handshake
- bresp  out  2 / bvalid  out  1 / bready  in  1  write response
- araddr  in  ADDR_WIDTH  read address
- arvalid  in  1 / arready  out  1  read-address handshake
- rdata  out  32 / rresp  out  2 / rvalid  out  1 / rready  in  1  read response
- reg_q  out  NUM_REGS*32  register contents; register i occupies bits [32i+31:32i]
- wr_pulse  out  NUM_REGS  one-cycle strobe per register written

Behaviour:
- Reset: axi4l_arstn, asynchronous, active-high; clock axi4l_aclk.
- While reset is asserted: all registers, reg_q, wr_pulse, bvalid, rvalid, rdata and holding flags are 0; bresp and rresp are 2'b00; awready, wready and arready are 0.
- awready, wready and arready rise in the first cycle after reset deasserts.
- Reset asserted mid-transaction drops any in-flight AW, W, B or R state; no partial write occurs.
- Address decode: idx = addr[ADDR_WIDTH-1:2]; addr[1:0] is ignored. idx >= NUM_REGS is out of range.
- Write channel states:
  - IDLE: AW and W are captured independently into holding registers; they may arrive in either order or in the same cycle.
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - The edge after both aw_held and w_held are true (or after a same-cycle AW+W handshake) is the commit edge.
  - On the commit edge: byte lanes with wstrb[k]=1 are updated; wr_pulse[idx] is asserted for exactly 1 cycle; bvalid goes to 1; both holding flags are cleared.
  - RESP: bvalid stays high with bresp held stable until bready=1. On that edge bvalid goes to 0 and the block returns to IDLE.
  - Latency: bvalid and the updated reg_q appear 1 cycle after the later of the AW/W handshakes.
- Write response codes:
  - In range: bresp = 2'b00 (OKAY).
  - Out of range: bresp = 2'b10 (SLVERR), no register change, no wr_pulse.
  - wstrb=0 in range: OKAY, data unchanged, wr_pulse still asserted.
- Read channel:
  - arready = !rvalid.
  - On the AR handshake edge: rdata/rresp are registered and rvalid goes to 1. Latency is 1 cycle.
  - rdata and rresp are held stable until rready=1; rvalid then drops on that edge.
  - The next AR is accepted only once rvalid is low, so back-to-back reads take 2 cycles each when rready is held high.
  - Out of range: rdata = 0, rresp = 2'b10.
- Collision: a read and a write commit to the same register on the same edge return the pre-write value.
- The read and write channels are otherwise fully independent.

Optional Feature:
- Macro AXI4L_REGS_ID_EN.
- Defined:
  - Index 0 is read-only and always reads ID_VALUE with OKAY.
  - Writes to index 0 return SLVERR, change nothing and produce no wr_pulse.
  - reg_q[31:0] = ID_VALUE.
- Undefined: index 0 is an ordinary read/write register; ID_VALUE is unused.

Test Plan:
- Reset, then read addresses 0x0, 0x4, 0x8, 0xC -> rdata 0 with rresp OKAY for each; rvalid rises 1 cycle after each AR handshake.
- Write 0x12345678 to 0x4 (wstrb=4'hF), with W presented 3 cycles before AW:
  - bvalid rises 1 cycle after the AW handshake, with bresp OKAY.
  - wr_pulse[1] is a 1-cycle pulse.
  - Readback of 0x4 = 0x12345678.
- Write 0xFFFFFFFF to 0x4 with wstrb=4'b0101 and bready held low for 5 cycles:
  - bvalid is held for those 5 cycles, and awready/wready stay low throughout.
  - Readback of 0x4 = 0x12FF56FF.
- Access address 4*NUM_REGS (0x40 at defaults):
  - Write -> bresp 2'b10, no wr_pulse, all reg_q unchanged.
  - Read -> rdata 0, rresp 2'b10.
- Assert reset while bvalid=1 and rvalid=1 -> both drop to 0 asynchronously and all registers read 0 after release.
- With AXI4L_REGS_ID_EN defined:
  - Read 0x0 -> 0xA5A50001, OKAY.
  - Write 0x0 -> SLVERR, and readback is still 0xA5A50001.
